// File: rtl/fetch_pkg.sv
// Shared defaults and the queue-entry type for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_QDEPTH   = 4;
  localparam int DEF_RESET_PC = 0;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of loader, redirect and decode-side signals around the fetch unit.
interface fetch_if import fetch_pkg::*; #(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int QDEPTH  = DEF_QDEPTH
) ();

  localparam int PA_W  = $clog2(DEPTH);
  localparam int LVL_W = $clog2(QDEPTH) + 1;

  logic               load_mode;
  logic               prog_we;
  logic [PA_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_base;
  logic [ADDR_W-1:0]  redirect_delta;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [LVL_W-1:0]   queue_level;

  // master: the fetch unit itself; slave: loader, execute and decode around it.
  modport master (
    input  load_mode, prog_we, prog_addr, prog_data,
    input  redirect_valid, redirect_base, redirect_delta,
    input  out_ready,
    output out_valid, out_instr, out_pc, queue_level
  );

  modport slave (
    output load_mode, prog_we, prog_addr, prog_data,
    output redirect_valid, redirect_base, redirect_delta,
    output out_ready,
    input  out_valid, out_instr, out_pc, queue_level
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, occupancy output and combinational head view.
module fetch_queue import fetch_pkg::*; #(
  parameter int W     = DEF_INSTR_W + DEF_ADDR_W,
  parameter int DEPTH = DEF_QDEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  input  logic                   i_pop,
  output logic                   o_head_valid,
  output logic [W-1:0]           o_head_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_level;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == (PW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Flush behaves like reset for the pointers; stale storage is never visible.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !reset && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_valid = !w_empty;
  assign o_head_data  = r_mem[r_rd_ptr];
  assign o_level      = r_level;

endmodule

// File: rtl/fetch_unit.sv
// Instruction memory, PC and prefetch queue delivering instructions to decode,
// with program download and branch redirect (base + signed delta).
module fetch_unit import fetch_pkg::*; #(
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                QDEPTH   = DEF_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);

  localparam int MA_W  = $clog2(DEPTH);
  localparam int LVL_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = INSTR_W + ADDR_W;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rd_data;
  logic [ADDR_W-1:0]  r_rd_pc;
  logic               r_rd_valid;
  logic [ADDR_W-1:0]  r_pc;

  logic               w_redirect;
  logic               w_flush;
  logic               w_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;
  logic               w_head_valid;
  logic [ENT_W-1:0]   w_head_data;
  logic [LVL_W-1:0]   w_level;

  assign w_redirect = bus.redirect_valid && !bus.load_mode;
  assign w_flush    = bus.load_mode || w_redirect;

  // Credit counts the read in the memory pipeline; a pop this cycle frees nothing yet.
  assign w_credit = (({1'b0, w_level} + (LVL_W+1)'(r_rd_valid)) < (LVL_W+1)'(QDEPTH));
  assign w_issue  = !bus.load_mode && !bus.redirect_valid && w_credit;

  // A flush in the same cycle kills the read that would otherwise land now.
  assign w_push      = r_rd_valid && !w_flush;
  assign w_out_valid = w_head_valid && !bus.load_mode;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (bus.load_mode)        r_pc <= RESET_PC;
      else if (w_redirect)      r_pc <= bus.redirect_base + bus.redirect_delta;
      else if (w_issue)         r_pc <= r_pc + 1'b1;
    end
  end

  // Download writes and fetch reads never coincide: issue is blocked in load mode.
  always_ff @(posedge clk) begin
    if (bus.load_mode && bus.prog_we) r_mem[bus.prog_addr] <= bus.prog_data;
    if (w_issue) begin
      r_rd_data <= r_mem[r_pc[MA_W-1:0]];
      r_rd_pc   <= r_pc;
    end
  end

  fetch_queue #(
    .W     (ENT_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (w_flush),
    .i_push       (w_push),
    .i_push_data  ({r_rd_data, r_rd_pc}),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data),
    .o_level      (w_level)
  );

  assign bus.out_valid   = w_out_valid;
  assign bus.out_instr   = w_out_valid ? w_head_data[ENT_W-1:ADDR_W] : '0;
  assign bus.out_pc      = w_out_valid ? w_head_data[ADDR_W-1:0]     : '0;
  assign bus.queue_level = w_level;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences
// and a randomized run scored against a stream-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int IW    = 16;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int QD    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .QDEPTH(QD)) bus ();

  fetch_unit #(
    .INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .QDEPTH(QD), .RESET_PC(32'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [3:0]  exp_level;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IW-1:0] model_mem [DEPTH];
  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [AW-1:0] pc);
    fetch_entry_t e;
    logic [7:0] idx;
    idx     = pc[7:0];
    e.pc    = pc;
    e.instr = model_mem[idx];
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_entry"}, 64'({bus.out_instr, bus.out_pc}), 64'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.prog_we        = 1'b0;
    bus.prog_addr      = '0;
    bus.prog_data      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_base  = '0;
    bus.redirect_delta = '0;
  endtask

  // Redirect in cycle R with a head accepted in R; bubbles in R+1, R+2; target in R+3.
  task automatic redirect_seq(input string name, input logic [AW-1:0] head_pc,
                              input logic [AW-1:0] base, input logic [AW-1:0] delta);
    logic [AW-1:0] tgt;
    tgt = base + delta;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_base  = base;
    bus.redirect_delta = delta;
    @(negedge clk);
    check_head({name, "_R"}, head_pc);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check({name, "_R1_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_R1_level"}, 64'(bus.queue_level), 64'd0);
    tick();
    @(negedge clk);
    check({name, "_R2_valid"}, 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check_head({name, "_R3"}, tgt);
    $display("[TB] %s redirect delivered pc=%0d instr=%h", name, bus.out_pc, bus.out_instr);
    tick();
    @(negedge clk);
    check_head({name, "_R4"}, tgt + 32'd1);
    $display("[TB] %s follow-on pc=%0d instr=%h", name, bus.out_pc, bus.out_instr);
    tick();
  endtask

  // Fetch restart from RESET_PC: empty for two cycles, then pc 0 at the head.
  task automatic restart_seq(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_T0_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_T0_level"}, 64'(bus.queue_level), 64'd0);
    tick();
    @(negedge clk);
    check({name, "_T1_valid"}, 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk);
    check_head({name, "_T2"}, 32'd0);
    $display("[TB] %s restart pc=%0d instr=%h", name, bus.out_pc, bus.out_instr);
    tick();
  endtask

  initial begin
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] base;
    logic [AW-1:0] delta;
    logic          redir;
    logic          started;
    int            blank;
    int            pops;

    tbl[0]  = '{1'b0, 1'b0, 32'd0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd0, 4'd1};
    tbl[3]  = '{1'b0, 1'b1, 32'd0, 4'd2};
    tbl[4]  = '{1'b0, 1'b1, 32'd0, 4'd3};
    tbl[5]  = '{1'b0, 1'b1, 32'd0, 4'd4};
    tbl[6]  = '{1'b0, 1'b1, 32'd0, 4'd4};
    tbl[7]  = '{1'b1, 1'b1, 32'd0, 4'd4};
    tbl[8]  = '{1'b1, 1'b1, 32'd1, 4'd3};
    tbl[9]  = '{1'b1, 1'b1, 32'd2, 4'd2};
    tbl[10] = '{1'b1, 1'b1, 32'd3, 4'd2};
    tbl[11] = '{1'b1, 1'b1, 32'd4, 4'd2};
    tbl[12] = '{1'b1, 1'b1, 32'd5, 4'd2};
    tbl[13] = '{1'b1, 1'b1, 32'd6, 4'd2};
    tbl[14] = '{1'b1, 1'b1, 32'd7, 4'd2};

    // Reset state
    reset = 1'b1;
    bus.load_mode = 1'b1;
    bus.out_ready = 1'b1;
    quiet_inputs();
    @(negedge clk);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_instr", 64'(bus.out_instr), 64'd0);
    check("reset_pc",    64'(bus.out_pc),    64'd0);
    check("reset_level", 64'(bus.queue_level), 64'd0);
    tick();
    reset = 1'b0;

    // Program download; a redirect in load mode must be ignored
    for (int i = 0; i < DEPTH; i++) begin
      logic [IW-1:0] d;
      d = (i < 8) ? IW'(16'hA000 + i) : IW'($urandom);
      model_mem[i]       = d;
      bus.prog_we        = 1'b1;
      bus.prog_addr      = 8'(i);
      bus.prog_data      = d;
      bus.redirect_valid = (i == 20);
      bus.redirect_base  = 32'd100;
      if (i == 30) begin
        @(negedge clk);
        check("load_valid", 64'(bus.out_valid), 64'd0);
      end
      tick();
    end
    bus.load_mode = 1'b0;
    quiet_inputs();

    // Stream with backpressure; prog_we pulses must not alter memory
    for (int i = 0; i < 15; i++) begin
      bus.out_ready = tbl[i].ready;
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'(i);
      bus.prog_data = 16'hFFFF;
      @(negedge clk);
      check("tbl_level", 64'(bus.queue_level), 64'(tbl[i].exp_level));
      if (tbl[i].exp_valid) check_head("tbl", tbl[i].exp_pc);
      else check("tbl_valid", 64'(bus.out_valid), 64'd0);
      $display("[TB] row %0d ready=%0d valid=%0d pc=%0d instr=%h level=%0d",
               i, bus.out_ready, bus.out_valid, bus.out_pc, bus.out_instr, bus.queue_level);
      tick();
    end
    quiet_inputs();

    redirect_seq("redir", 32'd8, 32'd5, 32'hFFFF_FFFD);
    redirect_seq("wrap",  32'd4, 32'd250, 32'd5);

    // Randomized run against the stream model
    started = 1'b0;
    blank   = 0;
    pops    = 0;
    exp_pc  = '0;
    for (int i = 0; i < 1500; i++) begin
      redir = (i == 0) || ($urandom_range(0, 19) == 0);
      base  = $urandom;
      delta = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 16) - 8);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = redir;
      bus.redirect_base  = base;
      bus.redirect_delta = delta;
      bus.prog_we        = $urandom_range(0, 1) == 1;
      bus.prog_addr      = 8'($urandom);
      bus.prog_data      = 16'($urandom);
      @(negedge clk);
      check("rnd_level_bound", 64'(bus.queue_level > 4'(QD)), 64'd0);
      if (blank > 0) begin
        check("rnd_bubble", 64'(bus.out_valid), 64'd0);
        blank--;
      end else if (started && bus.out_valid) begin
        check_head("rnd", exp_pc);
      end
      if (started && bus.out_valid && bus.out_ready) begin
        $display("[TB] pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc = exp_pc + 32'd1;
        pops++;
      end
      if (redir) begin
        exp_pc  = base + delta;
        blank   = 2;
        started = 1'b1;
      end
      tick();
    end
    quiet_inputs();
    check("rnd_liveness", 64'(pops > 300), 64'd1);

    // Load mode entered mid-stream
    bus.out_ready = 1'b1;
    bus.load_mode = 1'b1;
    @(negedge clk);
    check("midload_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_base  = 32'd77;
    @(negedge clk);
    check("midload_level", 64'(bus.queue_level), 64'd0);
    tick();
    bus.load_mode = 1'b0;
    quiet_inputs();
    restart_seq("loadexit");

    // Reset mid-stream
    reset = 1'b1;
    tick();
    reset = 1'b0;
    restart_seq("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
